// File: rtl/zuart_module_rx_if.sv
// Receive-side holding-register bundle of the UART receiver.
// The master drives received data and status; the slave supplies rx_ready.
interface zuart_module_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_overrun,
        output rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_overrun,
        input  rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/zuart_module_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation,
// LSB-first centre sampling, valid/ready holding register with
// framing-error and overrun pulses. One bit period is CLK_DIV cycles.
module zuart_module_rx #(
    parameter int CLK_DIV = 434,
    parameter int HALF    = CLK_DIV / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    zuart_module_rx_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] CNT_HALF = 16'(HALF);

    logic        sync_m_q;
    logic        sync_s_q;
    logic        rx_s;

    state_t      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [2:0]  idx_q,   idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q,  data_d;
    logic        valid_q, valid_d;
    logic        ferr_q,  ferr_d;
    logic        ovr_q,   ovr_d;
    logic        busy_q,  busy_d;
    logic        good;

    assign rx_s = sync_s_q;

    // Two-flop synchroniser for the asynchronous rx pin; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_m_q <= 1'b1;
            sync_s_q <= 1'b1;
        end else begin
            sync_m_q <= rx;
            sync_s_q <= sync_m_q;
        end
    end

    // Frame sequencing, bit timing and holding-register next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        good    = 1'b0;

        // A consumer transfer empties the holding register unless refilled below.
        if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CNT_HALF) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 16'd0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CNT_LAST) begin
                    if (rx_s) begin
                        good    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line recovers so a long low is not a new start.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end

        // A full, unconsumed holding register drops the new byte.
        if (good) begin
            if (valid_q && !bus.rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_overrun   = ovr_q;
    assign bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_zuart_module_rx.sv
// Bench for zuart_module_rx: directed serial frames, an event-schedule
// model of the expected outputs, and literal checks of key timings.
module tb_zuart_module_rx;

    localparam int CLK_DIV = 434;
    localparam int HALF    = CLK_DIV / 2;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rx    = 1'b1;
    logic ready = 1'b1;

    int n        = 0;
    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int ovr_edge = -1;
    int ferr_cnt = 0;
    int busy_cnt = 0;

    // Expected events keyed by clock-edge number: 1 = good byte, 2 = framing error.
    int         ev_kind[int];
    logic [7:0] ev_byte[int];
    logic       busy_ev[int];

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_busy  = 1'b0;
    logic       e_ferr  = 1'b0;
    logic       e_ovr   = 1'b0;

    zuart_module_rx_if bus();
    assign bus.rx_ready = ready;

    zuart_module_rx #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, n);
        end
    endtask

    task automatic hold(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_edge_neg(input int e);
        while (n < e) @(negedge clk);
    endtask

    // Drives one 8N1 frame starting at the current negedge and records the
    // outputs the receiver must produce for it.
    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        int t0;
        int s;
        t0 = n + 1;
        s  = t0 + HALF + 3 + 9 * CLK_DIV;
        busy_ev[t0 + 2] = 1'b1;
        if (stop_b) begin
            ev_kind[s] = 1;
            ev_byte[s] = b;
            busy_ev[s] = 1'b0;
        end else begin
            ev_kind[s] = 2;
        end
        rx = 1'b0;
        hold(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CLK_DIV);
        end
        rx = stop_b;
        hold(CLK_DIV);
    endtask

    // Per-cycle model update and comparison, sampled 1 time unit after each edge.
    always @(posedge clk) begin
        #1;
        n = n + 1;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_busy  = 1'b0;
            ev_kind.delete();
            ev_byte.delete();
            busy_ev.delete();
        end else begin
            if (ev_kind.exists(n) && ev_kind[n] == 1) begin
                if (m_valid && !ready) begin
                    e_ovr = 1'b1;
                end else begin
                    m_data  = ev_byte[n];
                    m_valid = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            if (ev_kind.exists(n) && ev_kind[n] == 2) e_ferr = 1'b1;
            if (busy_ev.exists(n)) m_busy = busy_ev[n];
        end
        chk("model_valid", 32'(bus.rx_valid), 32'(m_valid));
        chk("model_data", 32'(bus.rx_data), 32'(m_data));
        chk("model_frame_err", 32'(bus.rx_frame_err), 32'(e_ferr));
        chk("model_overrun", 32'(bus.rx_overrun), 32'(e_ovr));
        chk("model_busy", 32'(bus.rx_busy), 32'(m_busy));
        if (bus.rx_overrun) begin
            ovr_cnt++;
            ovr_edge = n;
        end
        if (bus.rx_frame_err) ferr_cnt++;
        if (bus.rx_busy) busy_cnt++;
    end

    initial begin
        #(200000 * 10);
        failures++;
        $display("FAIL watchdog: got timeout expected finish at edge %0d", n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int t1;
        int tg;
        logic [7:0] b3c;

        // Reset values.
        hold(4);
        chk("reset_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset_data", 32'(bus.rx_data), 32'h00);
        chk("reset_busy", 32'(bus.rx_busy), 32'd0);
        chk("reset_flags", 32'({bus.rx_frame_err, bus.rx_overrun}), 32'd0);
        rst = 1'b0;
        hold(CLK_DIV);

        // Single byte with ready held high.
        ready = 1'b1;
        base  = n + 1;
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_edge_neg(base + 4125);
                chk("single_valid_before", 32'(bus.rx_valid), 32'd0);
                @(negedge clk);
                chk("single_valid", 32'(bus.rx_valid), 32'd1);
                chk("single_data", 32'(bus.rx_data), 32'h55);
                @(negedge clk);
                chk("single_valid_1cyc", 32'(bus.rx_valid), 32'd0);
            end
        join

        // Back-to-back with the consumer stalled.
        ready = 1'b0;
        hold(CLK_DIV);
        base = n + 1;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        chk("stall_overrun_count", 32'(ovr_cnt), 32'd1);
        chk("stall_overrun_edge", 32'(ovr_edge), 32'(base + 4340 + 4126));
        chk("stall_data", 32'(bus.rx_data), 32'hA3);
        chk("stall_valid", 32'(bus.rx_valid), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("stall_drain", 32'(bus.rx_valid), 32'd0);

        // Transfer on the same edge as the second delivery.
        hold(CLK_DIV);
        base = n + 1;
        fork
            begin
                send_frame(8'hA3, 1'b1);
                send_frame(8'h0F, 1'b1);
            end
            begin
                wait_edge_neg(base + 4340 + 4126 - 1);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        chk("coincide_data", 32'(bus.rx_data), 32'h0F);
        chk("coincide_valid", 32'(bus.rx_valid), 32'd1);
        chk("coincide_no_overrun", 32'(ovr_cnt), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        chk("coincide_drain", 32'(bus.rx_valid), 32'd0);

        // Framing error followed by a held-low line.
        hold(CLK_DIV);
        send_frame(8'hFF, 1'b0);
        hold(3000);
        rx = 1'b1;
        t1 = n + 1;
        busy_ev[t1 + 2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("break_busy_t1p1", 32'(bus.rx_busy), 32'd1);
        @(negedge clk);
        chk("break_busy_t1p2", 32'(bus.rx_busy), 32'd0);
        hold(CLK_DIV);
        chk("ferr_count", 32'(ferr_cnt), 32'd1);
        chk("ferr_valid", 32'(bus.rx_valid), 32'd0);

        // Short glitch on the idle line.
        rx = 1'b0;
        tg = n + 1;
        busy_ev[tg + 2]        = 1'b1;
        busy_ev[tg + HALF + 3] = 1'b0;
        busy_cnt = 0;
        hold(100);
        rx = 1'b1;
        hold(CLK_DIV);
        chk("glitch_busy_cycles", 32'(busy_cnt), 32'd218);
        chk("glitch_valid", 32'(bus.rx_valid), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt), 32'd1);

        // Byte after the break, left pending in the holding register.
        ready = 1'b0;
        send_frame(8'h81, 1'b1);
        hold(CLK_DIV);
        chk("after_break_data", 32'(bus.rx_data), 32'h81);
        chk("after_break_valid", 32'(bus.rx_valid), 32'd1);

        // Reset in the middle of the data bits of 0x3C.
        b3c = 8'h3C;
        busy_ev[n + 3] = 1'b1;
        rx = 1'b0;
        hold(CLK_DIV);
        for (int i = 0; i < 4; i++) begin
            rx = b3c[i];
            hold(CLK_DIV);
        end
        hold(CLK_DIV / 2);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(bus.rx_valid), 32'd0);
        chk("midrst_data", 32'(bus.rx_data), 32'h00);
        chk("midrst_busy", 32'(bus.rx_busy), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b1;
        hold(CLK_DIV);
        base = n + 1;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_edge_neg(base + 4126);
                chk("postrst_valid", 32'(bus.rx_valid), 32'd1);
                chk("postrst_data", 32'(bus.rx_data), 32'hC3);
            end
        join

        hold(100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zuart_module_rx.md
# zuart_module_rx

UART receiver for 8N1 serial data. It shares the bit-period convention of the team's transmit-side baud generator: one bit period is CLK_DIV clock cycles, and the nominal setting is 434 cycles at 50 MHz for 115200 bps. It synchronises the asynchronous `rx` pin, validates the start bit at mid-bit, and samples data LSB-first at bit centres. Each good byte is presented on a valid/ready holding register, and framing and overrun events are flagged.

## Interface
- `CLK_DIV`, 434: clock cycles per bit. Legal range is 16..65535.
- `HALF`, CLK_DIV/2 (integer division): cycle offset for the start-bit mid-point check.
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input. The line idles high.
- `rx_data` out 8: last good byte received.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `rx_frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `rx_overrun` out 1: one-cycle pulse when a good byte is dropped because the holding register is full.
- `rx_busy` out 1: high whenever the state is not IDLE.

## Operation
- **Synchroniser.** `rx` passes through two flops to give `rx_s`. Both flops reset to 1.
- **Bit counter.** `cnt` is 16 bits wide and is cleared on every state change. It increments once per cycle in START, DATA and STOP.
- **IDLE.**
  - If `rx_s` is 0, go to START.
- **START.**
  - When `cnt==HALF`: if `rx_s` is 0, go to DATA with bit index 0.
  - Otherwise (glitch or false start), go to IDLE with no flags raised.
- **DATA.**
  - When `cnt==CLK_DIV-1`, shift `rx_s` into shift-register bit [7], shifting right so the byte arrives LSB first.
  - Increment the bit index.
  - After the 8th sample, go to STOP.
- **STOP.** When `cnt==CLK_DIV-1`, sample `rx_s`:
  - If 1: the byte is good. Deliver it (see handshake) and go to IDLE.
  - If 0: pulse `rx_frame_err`, discard the byte and go to BREAK.
- **BREAK.**
  - Wait until `rx_s` is 1, then go to IDLE.
  - This prevents a held-low line from re-triggering as a start bit.
- **Handshake.**
  - A transfer occurs on any cycle where `rx_valid` and `rx_ready` are both 1. `rx_valid` clears on the next edge unless a new byte is delivered on that same edge.
  - Good byte while `rx_valid` is 0, or while `rx_valid & rx_ready` holds: load `rx_data` and set `rx_valid`. No overrun.
  - Good byte while `rx_valid` is 1 and `rx_ready` is 0: keep the old `rx_data`, drop the new byte, and pulse `rx_overrun`.
  - `rx_data` is stable whenever `rx_valid` is 1 and no transfer occurs.
  - `rx_ready` has no effect while `rx_valid` is 0.

## Timing
- **Reset values.**
  - State IDLE, `cnt` 0, bit index 0, shift register 0.
  - `rx_data` 0x00, `rx_valid` 0, `rx_frame_err` 0, `rx_overrun` 0, `rx_busy` 0.
- **Reset mid-frame.** Asserting `rst` mid-frame aborts the frame on the next edge with no flags. The partial byte is lost, and a pending `rx_valid` is cleared.
- **Synchroniser latency.** Let t0 be the first edge at which `rx` is captured low. `rx_s` is low from edge t0+1. The START entry edge is therefore t0+2.
- **Start check.** Made at edge t0+HALF+3.
- **Data bit k sample edge.** t0+HALF+3+(k+1)·CLK_DIV, for k = 0..7.
- **Stop sample edge.** t0+HALF+3+9·CLK_DIV. The outputs `rx_valid`, `rx_frame_err` and `rx_overrun` update at this edge.
- **Defaults (CLK_DIV=434, HALF=217).**
  - Bit k sampled at t0+220+434(k+1).
  - Stop sampled and `rx_valid` rising at t0+4126.
- **Back-to-back frames.**
  - The receiver returns to IDLE half a bit before the nominal stop-bit end, so back-to-back frames are received without loss.
  - Tolerated transmitter rate error is ±4%.
- **`rx_busy`.** Registered. It goes high on the START entry edge and low on the edge that enters IDLE.

## Test plan
- **Single byte.** Reset, then send 0x55 at 115207 bps (434 cycles per bit) with `rx_ready` held 1. Required: `rx_valid` high at t0+4126 for exactly 1 cycle, `rx_data`=0x55, no flags.
- **Back-to-back with stall.** Send 0xA3 then 0x0F back-to-back with `rx_ready`=0, then raise `rx_ready` for one cycle. Required:
  - `rx_data`=0xA3 persists.
  - `rx_overrun` pulses once at the second stop-sample edge.
  - `rx_valid` clears after the transfer.
- **Transfer coinciding with delivery.** Assert `rx_ready` on exactly the cycle the second good byte (0x0F) is delivered. Required: no overrun, `rx_data`=0x0F, `rx_valid` stays 1.
- **Framing error and break.** Send 0xFF with the stop bit forced low, then hold `rx` low for 3000 cycles before returning high. Required:
  - `rx_frame_err` pulses once and `rx_valid` stays 0.
  - `rx_busy` stays high until 2 cycles after `rx` returns high.
  - A following 0x81 is received correctly.
- **Glitch rejection.** Drive a 100-cycle low pulse on idle `rx`. Required: `rx_busy` high for about 218 cycles, then IDLE, with no `rx_valid` or flags.
- **Reset mid-frame.** Assert `rst` mid-way through the data bits of 0x3C. Required:
  - All outputs are at reset values on the next edge.
  - After `rst` deasserts and the line idles for 1 bit, 0xC3 is received intact.
